// File: rtl/data_router_ctrl.sv
// rtl/data_router_ctrl.sv - Router command sequencer: walks bank/row/col per block in RR, BR or RP order.
module data_router_ctrl #(
    parameter int POY    = 3,
    parameter int BUFH   = 3,
    parameter int BUFW   = 32,
    parameter int KSIZE  = 3,
    parameter int STRIDE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [15:0] nblk,
    input  logic        blkend,
    input  logic        cmd_stall,
    output logic [1:0]  bank,
    output logic [1:0]  row,
    output logic [27:0] col,
    output logic [1:0]  rpsel,
    output logic        cmd_vld,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_BLK = 2'd1;
    localparam logic [1:0] ISSUE    = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    localparam logic [1:0] MODE_RR = 2'b00;
    localparam logic [1:0] MODE_BR = 2'b01;

    // A block never issues more rows than a bank buffer holds.
    localparam int         ROWS      = (KSIZE < BUFH) ? KSIZE : BUFH;
    localparam logic [1:0] ROW_LAST  = 2'(ROWS - 1);
    localparam logic [1:0] BANK_LAST = 2'(POY - 1);

    logic [1:0]  state;
    logic [1:0]  mode_q;
    logic [15:0] blk_left;
    logic [1:0]  bank_cnt;
    logic [1:0]  row_cnt;
    logic [27:0] col_cnt;
    logic        pending;
    logic [1:0]  err_q;

    logic        row_last;
    logic        bank_last;
    logic        col_last;
    logic        blk_last;
    logic [28:0] col_nxt;

    assign row_last  = (row_cnt == ROW_LAST);
    assign bank_last = (bank_cnt == BANK_LAST);
    assign col_nxt   = {1'b0, col_cnt} + 29'(STRIDE);
    assign col_last  = (col_nxt >= 29'(BUFW));

    always_comb begin
        blk_last = 1'b0;
        case (mode_q)
            MODE_RR: blk_last = row_last;
            MODE_BR: blk_last = bank_last && row_last;
            default: blk_last = row_last && col_last;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mode_q   <= 2'b00;
            blk_left <= 16'd0;
            bank_cnt <= 2'd0;
            row_cnt  <= 2'd0;
            col_cnt  <= 28'd0;
            pending  <= 1'b0;
            err_q    <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (mode == 2'b11) begin
                            err_q[0] <= 1'b1;
                        end else begin
                            mode_q   <= mode;
                            blk_left <= nblk;
                            err_q    <= 2'b00;
                            pending  <= 1'b0;
                            state    <= (nblk == 16'd0) ? DONE : WAIT_BLK;
                        end
                    end
                end
                WAIT_BLK: begin
                    if (blkend || pending) begin
                        pending <= 1'b0;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // An early blkend is remembered once; a second one is lost and flagged.
                    if (blkend) begin
                        if (pending) begin
                            err_q[1] <= 1'b1;
                        end else begin
                            pending <= 1'b1;
                        end
                    end
                    if (!cmd_stall) begin
                        if (blk_last) begin
                            bank_cnt <= 2'd0;
                            row_cnt  <= 2'd0;
                            col_cnt  <= 28'd0;
                            blk_left <= blk_left - 16'd1;
                            state    <= (blk_left == 16'd1) ? DONE : WAIT_BLK;
                        end else begin
                            case (mode_q)
                                MODE_RR: row_cnt <= row_cnt + 2'd1;
                                MODE_BR: begin
                                    if (row_last) begin
                                        row_cnt  <= 2'd0;
                                        bank_cnt <= bank_cnt + 2'd1;
                                    end else begin
                                        row_cnt <= row_cnt + 2'd1;
                                    end
                                end
                                default: begin
                                    if (col_last) begin
                                        col_cnt <= 28'd0;
                                        row_cnt <= row_cnt + 2'd1;
                                    end else begin
                                        col_cnt <= col_nxt[27:0];
                                    end
                                end
                            endcase
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_vld = (state == ISSUE);
    assign bank    = cmd_vld ? bank_cnt : 2'd0;
    assign row     = cmd_vld ? row_cnt  : 2'd0;
    assign col     = cmd_vld ? col_cnt  : 28'd0;
    assign rpsel   = cmd_vld ? mode_q   : 2'd0;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign err     = err_q;

endmodule

// File: tb/tb_data_router_ctrl.sv
// tb/tb_data_router_ctrl.sv - Bench for data_router_ctrl: queue-based reference model plus directed job checks.
module tb_data_router_ctrl;

    localparam int POY = 3, BUFH = 3, BUFW = 32, KSIZE = 3, STRIDE = 2;

    logic        clk = 1'b0;
    logic        rst, start, blkend, cmd_stall;
    logic [1:0]  mode;
    logic [15:0] nblk;
    logic [1:0]  bank, row, rpsel, err;
    logic [27:0] col;
    logic        cmd_vld, busy, done;

    data_router_ctrl #(.POY(POY), .BUFH(BUFH), .BUFW(BUFW), .KSIZE(KSIZE), .STRIDE(STRIDE)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .nblk(nblk), .blkend(blkend),
        .cmd_stall(cmd_stall), .bank(bank), .row(row), .col(col), .rpsel(rpsel),
        .cmd_vld(cmd_vld), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {int bank; int row; int col; int sel;} cmd_t;

    cmd_t q[$];
    int   ph;          // 0 idle, 1 waiting for block, 2 issuing, 3 done
    int   left;
    bit   pend;
    int   merr;
    int   total = 0;
    int   bad = 0;
    int   n_issued = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic void fill(input int md);
        q.delete();
        if (md == 0) begin
            for (int r = 0; r < KSIZE; r++) q.push_back('{0, r, 0, 0});
        end else if (md == 1) begin
            for (int b = 0; b < POY; b++)
                for (int r = 0; r < KSIZE; r++) q.push_back('{b, r, 0, 1});
        end else begin
            for (int r = 0; r < KSIZE; r++)
                for (int c = 0; c < BUFW; c += STRIDE) q.push_back('{0, r, c, 2});
        end
    endfunction

    int mmode;

    task automatic model_step();
        if (rst) begin
            ph = 0; q.delete(); left = 0; pend = 0; merr = 0; mmode = 0;
        end else begin
            case (ph)
                0: if (start) begin
                    if (mode == 2'b11) merr = merr | 1;
                    else begin
                        merr = 0; pend = 0; mmode = int'(mode); left = int'(nblk);
                        ph = (nblk == 0) ? 3 : 1;
                    end
                end
                1: if (blkend || pend) begin
                    pend = 0; fill(mmode); ph = 2;
                end
                2: begin
                    if (blkend) begin
                        if (pend) merr = merr | 2;
                        else pend = 1;
                    end
                    if (!cmd_stall) begin
                        void'(q.pop_front());
                        if (q.size() == 0) begin
                            left--;
                            ph = (left != 0) ? 1 : 3;
                        end
                    end
                end
                default: ph = 0;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("cmd_vld", 32'(cmd_vld), 32'(ph == 2));
        if (ph == 2 && q.size() > 0) begin
            chk("bank", 32'(bank), 32'(q[0].bank));
            chk("row", 32'(row), 32'(q[0].row));
            chk("col", 32'(col), 32'(q[0].col));
            chk("rpsel", 32'(rpsel), 32'(q[0].sel));
        end else begin
            chk("idle_cmd", {2'b0, bank, row, rpsel, col[23:0]}, 32'd0);
        end
        chk("busy", 32'(busy), 32'(ph != 0));
        chk("done", 32'(done), 32'(ph == 3));
        chk("err", 32'(err), 32'(merr));
        if (cmd_vld && !cmd_stall) n_issued++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int maxc);
        bit seen = 0;
        for (int k = 0; k < maxc && !seen; k++) begin
            @(negedge clk);
            seen = done;
            tick();
        end
        chk("done_timeout", 32'(seen), 32'd1);
    endtask

    logic ov[40];
    logic od[40];
    logic [1:0] orow[40];
    logic [1:0] oerr[40];

    initial begin
        rst = 1'b1; start = 0; blkend = 0; cmd_stall = 0; mode = 0; nblk = 0;
        #1;
        chk("rst_vld", 32'(cmd_vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // RR job, two blocks, blkend at relative cycles 5 and 12
        for (int c = 0; c < 20; c++) begin
            start = (c == 0); mode = 2'b00; nblk = 16'd2;
            blkend = (c == 5 || c == 12);
            @(negedge clk);
            ov[c] = cmd_vld; orow[c] = row; od[c] = done;
            tick();
        end
        start = 0; blkend = 0;
        for (int c = 0; c < 20; c++) begin
            bit ev;
            ev = (c >= 6 && c <= 8) || (c >= 13 && c <= 15);
            chk("rr_vld", 32'(ov[c]), 32'(ev));
            if (ev) chk("rr_row", 32'(orow[c]), (c < 10) ? 32'(c - 6) : 32'(c - 13));
            chk("rr_done", 32'(od[c]), 32'(c == 16));
        end

        // RP job with a three-cycle stall in the middle of row 0
        n_issued = 0;
        start = 1; mode = 2'b10; nblk = 16'd1; tick();
        start = 0; blkend = 1; tick();
        blkend = 0;
        begin
            int st = 0;
            bit seen = 0;
            for (int k = 0; k < 300 && !seen; k++) begin
                cmd_stall = (n_issued >= 5 && st < 3);
                if (cmd_stall) st++;
                @(negedge clk);
                if (cmd_stall) chk("rp_stall_col", 32'(col), 32'd10);
                seen = done;
                tick();
            end
            cmd_stall = 0;
            chk("rp_done", 32'(seen), 32'd1);
            chk("rp_count", 32'(n_issued), 32'd48);
        end

        // BR job: early blkend chains block 2, double early blkend flags overflow
        for (int c = 0; c < 34; c++) begin
            start = (c == 0); mode = 2'b01; nblk = 16'd3;
            blkend = (c == 1 || c == 4 || c == 14 || c == 16);
            @(negedge clk);
            ov[c] = cmd_vld; od[c] = done; oerr[c] = err;
            tick();
        end
        start = 0; blkend = 0;
        chk("br_gap", 32'(ov[11]), 32'd0);
        chk("br_chain", 32'(ov[12]), 32'd1);
        chk("br_blk3", 32'(ov[22]), 32'd1);
        chk("br_done", 32'(od[31]), 32'd1);
        chk("br_err", 32'(oerr[31]), 32'd2);

        // Illegal mode, then zero-block job
        start = 1; mode = 2'b11; nblk = 16'd5; tick();
        start = 0;
        chk("ill_err", 32'(err), 32'd3);
        chk("ill_busy", 32'(busy), 32'd0);
        tick();
        chk("ill_busy2", 32'(busy), 32'd0);
        n_issued = 0;
        start = 1; mode = 2'b00; nblk = 16'd0; tick();
        start = 0;
        chk("z_done", 32'(done), 32'd1);
        chk("z_err", 32'(err), 32'd0);
        tick();
        chk("z_done_off", 32'(done), 32'd0);
        chk("z_count", 32'(n_issued), 32'd0);

        // Reset in the middle of a BR block, then a fresh job
        start = 1; mode = 2'b01; nblk = 16'd2; tick();
        start = 0; blkend = 1; tick();
        blkend = 0; tick(); tick(); tick();
        rst = 1; #1;
        chk("mid_rst_vld", 32'(cmd_vld), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_bank", 32'(bank), 32'd0);
        tick();
        rst = 0; tick();
        start = 1; mode = 2'b01; nblk = 16'd1; tick();
        start = 0; blkend = 1; tick();
        blkend = 0;
        chk("fresh_vld", 32'(cmd_vld), 32'd1);
        chk("fresh_pos", 32'({bank, row}), 32'd0);
        wait_done(40);

        // start while busy and blkend while idle are both ignored
        start = 1; mode = 2'b00; nblk = 16'd1; tick();
        mode = 2'b10; nblk = 16'd9; tick();
        start = 0; blkend = 1; tick();
        blkend = 0;
        chk("ign_sel", 32'(rpsel), 32'd0);
        wait_done(20);
        blkend = 1; tick(); tick();
        blkend = 0;
        chk("ign_err", 32'(err), 32'd0);
        start = 1; mode = 2'b00; nblk = 16'd1; tick();
        start = 0; tick();
        chk("ign_pend", 32'(cmd_vld), 32'd0);
        blkend = 1; tick();
        blkend = 0;
        wait_done(20);

        // Random traffic against the model
        for (int k = 0; k < 4000; k++) begin
            rst       = ($urandom_range(0, 599) == 0);
            start     = ($urandom_range(0, 5) == 0);
            mode      = 2'($urandom_range(0, 3));
            nblk      = 16'($urandom_range(0, 3));
            blkend    = ($urandom_range(0, 7) == 0);
            cmd_stall = ($urandom_range(0, 3) == 0);
            tick();
        end
        rst = 0; start = 0; blkend = 0; cmd_stall = 0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_router_ctrl.md
DATA_ROUTER_CTRL -- requirements
Module: data_router_ctrl

Interface
REQ-001 Parameter POY, default 3, number of row banks driven by the router.
REQ-002 Parameter BUFH, default 3, buffer rows per bank; legal range 1..4.
REQ-003 Parameter BUFW, default 32, pixels per buffer row.
REQ-004 Parameter KSIZE, default 3, rows issued per block; legal range 1..BUFH.
REQ-005 Parameter STRIDE, default 1, column step in RP mode; legal range >= 1.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  one-cycle job request; sampled only in IDLE.
REQ-009 mode  input  2  routing mode captured at start: 00 RR, 01 BR, 10 RP, 11 illegal.
REQ-010 nblk  input  16  number of blocks in the job, captured at start.
REQ-011 blkend  input  1  one-cycle pulse from the router side: next block is loaded.
REQ-012 cmd_stall  input  1  hold request from downstream.
REQ-013 bank  output  2  bank select to the router.
REQ-014 row  output  2  row select to the router.
REQ-015 col  output  28  column select to the router.
REQ-016 rpsel  output  2  instruction to the router: 00 RR, 01 BR, 10 RP.
REQ-017 cmd_vld  output  1  high when bank/row/col/rpsel carry a live command.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse at job completion.
REQ-020 err  output  2  sticky flags: [0] illegal mode, [1] blkend overflow; cleared only by accepted start or reset.

Function
REQ-021 The FSM SHALL have states IDLE, WAIT_BLK, ISSUE, DONE.
REQ-022 In IDLE, start=1 with mode!=11 and nblk!=0 SHALL capture mode and nblk, clear err, and enter WAIT_BLK next cycle.
REQ-023 In IDLE, start=1 with mode=11 SHALL set err[0], remain in IDLE, and issue no commands.
REQ-024 In IDLE, start=1 with legal mode and nblk=0 SHALL enter DONE next cycle without issuing commands.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 WAIT_BLK SHALL leave for ISSUE the cycle after blkend=1 or the cycle after entry if a pending blkend flag is set; the pending flag clears on leaving.
REQ-027 In ISSUE, cmd_vld SHALL be 1 and one command SHALL advance per cycle while cmd_stall=0; with cmd_stall=1, all outputs and counters SHALL hold.
REQ-028 RR order: row 0..KSIZE-1, bank=0, col=0, rpsel=00; KSIZE commands per block.
REQ-029 BR order: bank outer 0..POY-1, row inner 0..KSIZE-1, col=0, rpsel=01; POY*KSIZE commands per block.
REQ-030 RP order: row outer 0..KSIZE-1, col inner 0,STRIDE,2*STRIDE..<BUFW, bank=0, rpsel=10; KSIZE*ceil(BUFW/STRIDE) commands per block.
REQ-031 After the last command of a block, the FSM SHALL decrement the remaining-block count and enter WAIT_BLK if it is nonzero, else DONE.
REQ-032 blkend=1 outside WAIT_BLK while busy SHALL set the pending flag; blkend while pending is already set SHALL set err[1] and be dropped.
REQ-033 blkend in IDLE or DONE SHALL be ignored.
REQ-034 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-035 Outside ISSUE, cmd_vld=0 and bank/row/col/rpsel SHALL be 0; rpsel=11 SHALL never be driven.

Reset
REQ-036 rst=1 SHALL immediately force IDLE, with all outputs, counters, the pending flag and err at 0, regardless of the current state.
REQ-037 Deassertion of rst SHALL leave the block in IDLE; no command is issued until a new start is accepted.

Verification
REQ-038 RR job: mode=00, nblk=2, KSIZE=3; blkend at cycles 5 and 12 -> rows 0,1,2 at cycles 6-8 and 13-15, done at cycle 16.
REQ-039 RP job: STRIDE=2, BUFW=32, KSIZE=3 -> 48 commands with col 0,2..30 per row; cmd_stall held for 3 cycles mid-row -> outputs frozen, no command skipped or duplicated.
REQ-040 BR job with blkend pulsed during ISSUE -> next block starts the cycle after WAIT_BLK entry; a second early blkend -> err[1]=1, job still completes.
REQ-041 start with mode=11 -> err=01, busy stays 0; start with nblk=0 -> done pulses 1 cycle later with zero commands.
REQ-042 rst asserted mid-ISSUE in BR mode -> all outputs 0 in the same cycle; a fresh start afterwards runs a full job from bank 0, row 0.
REQ-043 start asserted while busy and blkend asserted in IDLE -> both ignored, with no state or err change.
